// File: rtl/ps2_mouse_init_sequencer_if.sv
// PS/2 byte-link bundle between the init sequencer and the
// board-level transmitter/receiver.
interface ps2_mouse_init_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data,
    output tx_req,
    input  tx_busy,
    input  tx_done,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_req,
    output tx_busy,
    output tx_done,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse power-up sequencer: reset, BAT/ID check, enable
// reporting, with timeouts, resend handling and bounded retries.
module ps2_mouse_init_sequencer #(
  parameter int unsigned POWERUP_WAIT = 1_000_000,
  parameter int unsigned RESP_TIMEOUT = 2_500_000,
  parameter int unsigned BAT_TIMEOUT  = 100_000_000,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                        CLK_100MHZ,
  input  logic                        reset,
  input  logic                        restart,
  ps2_mouse_init_sequencer_if.master  ps2,
  output logic                        stream_en,
  output logic                        init_fail,
  output logic [1:0]                  retry_count,
  output logic [3:0]                  state_dbg
);

  localparam logic [3:0] ST_PWR    = 4'd0;
  localparam logic [3:0] ST_SRST   = 4'd1;
  localparam logic [3:0] ST_TRST   = 4'd2;
  localparam logic [3:0] ST_ARST   = 4'd3;
  localparam logic [3:0] ST_BAT    = 4'd4;
  localparam logic [3:0] ST_ID     = 4'd5;
  localparam logic [3:0] ST_SEN    = 4'd6;
  localparam logic [3:0] ST_TEN    = 4'd7;
  localparam logic [3:0] ST_AEN    = 4'd8;
  localparam logic [3:0] ST_STREAM = 4'd9;
  localparam logic [3:0] ST_FAIL   = 4'd10;

  localparam logic [7:0] CMD_RST = 8'hFF;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] B_ACK   = 8'hFA;
  localparam logic [7:0] B_RSND  = 8'hFE;
  localparam logic [7:0] B_BAT   = 8'hAA;
  localparam logic [7:0] B_ID    = 8'h00;

  localparam logic [31:0] PWR_LAST  = 32'(POWERUP_WAIT - 1);
  localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0] BAT_LAST  = 32'(BAT_TIMEOUT - 1);
  localparam logic [1:0]  TRY_LAST  = 2'(MAX_RETRIES - 1);
  localparam logic [1:0]  TRY_MAX   = 2'(MAX_RETRIES);

  logic [3:0]  state;
  logic [3:0]  state_n;
  logic [31:0] timer;
  logic [1:0]  retry_n;
  logic [7:0]  data_q;
  logic [7:0]  data_n;
  logic        req_q;
  logic        req_n;
  logic        fail;
  logic [3:0]  fail_to;
  logic        rx_v;
  logic [7:0]  rx_b;

  assign rx_v = ps2.rx_valid;
  assign rx_b = ps2.rx_data;

  always_comb begin
    state_n = state;
    retry_n = retry_count;
    data_n  = data_q;
    req_n   = 1'b0;
    fail    = 1'b0;
    fail_to = ST_SRST;
    case (state)
      ST_PWR: begin
        if (timer == PWR_LAST) state_n = ST_SRST;
      end
      ST_SRST: begin
        if (!ps2.tx_busy) begin
          data_n  = CMD_RST;
          req_n   = 1'b1;
          state_n = ST_TRST;
        end
      end
      ST_TRST: begin
        if (ps2.tx_done) state_n = ST_ARST;
      end
      // A byte arriving in the expiry cycle takes priority
      ST_ARST: begin
        if (rx_v) begin
          if (rx_b == B_ACK) state_n = ST_BAT;
          else               fail    = 1'b1;
        end else if (timer == RESP_LAST) begin
          fail = 1'b1;
        end
      end
      ST_BAT: begin
        if (rx_v) begin
          if (rx_b == B_BAT) state_n = ST_ID;
          else               fail    = 1'b1;
        end else if (timer == BAT_LAST) begin
          fail = 1'b1;
        end
      end
      ST_ID: begin
        if (rx_v) begin
          if (rx_b == B_ID) state_n = ST_SEN;
          else              fail    = 1'b1;
        end else if (timer == BAT_LAST) begin
          fail = 1'b1;
        end
      end
      ST_SEN: begin
        if (!ps2.tx_busy) begin
          data_n  = CMD_EN;
          req_n   = 1'b1;
          state_n = ST_TEN;
        end
      end
      ST_TEN: begin
        if (ps2.tx_done) state_n = ST_AEN;
      end
      ST_AEN: begin
        if (rx_v) begin
          unique case (1'b1)
            (rx_b == B_ACK): begin
              state_n = ST_STREAM;
              retry_n = 2'd0;
            end
            (rx_b == B_RSND): begin
              fail    = 1'b1;
              fail_to = ST_SEN;
            end
            default: fail = 1'b1;
          endcase
        end else if (timer == RESP_LAST) begin
          fail = 1'b1;
        end
      end
      ST_STREAM, ST_FAIL: begin
        if (restart) begin
          state_n = ST_SRST;
          retry_n = 2'd0;
        end
      end
      default: state_n = ST_PWR;
    endcase
    if (fail) begin
      if (retry_count == TRY_LAST) begin
        state_n = ST_FAIL;
        retry_n = TRY_MAX;
      end else begin
        state_n = fail_to;
        retry_n = retry_count + 2'd1;
      end
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state       <= ST_PWR;
      timer       <= '0;
      retry_count <= 2'd0;
      data_q      <= 8'h00;
      req_q       <= 1'b0;
      stream_en   <= 1'b0;
      init_fail   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= (state_n != state) ? '0 : timer + 32'd1;
      retry_count <= retry_n;
      data_q      <= data_n;
      req_q       <= req_n;
      stream_en   <= (state_n == ST_STREAM);
      init_fail   <= (state_n == ST_FAIL);
    end
  end

  assign ps2.tx_data = data_q;
  assign ps2.tx_req  = req_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Scenario bench for the PS/2 mouse init sequencer; expected
// command bytes go through a scoreboard queue.
module tb_ps2_mouse_init_sequencer;

  logic       clk;
  logic       reset;
  logic       restart;
  logic       stream_en;
  logic       init_fail;
  logic [1:0] retry_count;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  ps2_mouse_init_sequencer_if bus ();

  ps2_mouse_init_sequencer #(
    .POWERUP_WAIT(10),
    .RESP_TIMEOUT(50),
    .BAT_TIMEOUT (200),
    .MAX_RETRIES (3)
  ) dut (
    .CLK_100MHZ (clk),
    .reset      (reset),
    .restart    (restart),
    .ps2        (bus.master),
    .stream_en  (stream_en),
    .init_fail  (init_fail),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_req === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected data %h with nothing expected",
                 bus.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL tx_data actual %h required %h", bus.tx_data, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    restart      = 1'b0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(2);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.tx_req !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (bus.tx_req !== 1'b1) begin
      errors++;
      $display("FAIL %s tx_req actual %b required 1", tag, bus.tx_req);
    end
  endtask

  task automatic drive_tx(input logic [7:0] b, input string tag);
    exp_q.push_back(b);
    wait_req(tag);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic reach_ack_en();
    do_reset();
    drive_tx(8'hFF, "reach_rst");
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    rx_byte(8'h00);
    drive_tx(8'hF4, "reach_en");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state_dbg, retry_count, stream_en, init_fail} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state st %0d rc %0d se %b if %b required 0",
               state_dbg, retry_count, stream_en, init_fail);
    end
    checks++;
    if (bus.tx_req !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx req %b data %h required 0/00",
               bus.tx_req, bus.tx_data);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    tick(10);
    checks++;
    if (state_dbg !== 4'd1 || bus.tx_req !== 1'b0) begin
      errors++;
      $display("FAIL pwr_wait_end st %0d req %b required 1/0",
               state_dbg, bus.tx_req);
    end
    exp_q.push_back(8'hFF);
    wait_req("nom_rst");
    tick(1);
    checks++;
    if (bus.tx_req !== 1'b0 || state_dbg !== 4'd2) begin
      errors++;
      $display("FAIL req_pulse req %b st %0d required 0/2",
               bus.tx_req, state_dbg);
    end
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    rx_byte(8'h00);
    drive_tx(8'hF4, "nom_en");
    checks++;
    if (state_dbg !== 4'd8 || stream_en !== 1'b0) begin
      errors++;
      $display("FAIL ack_en_wait st %0d se %b required 8/0",
               state_dbg, stream_en);
    end
    rx_byte(8'hFA);
    checks++;
    if (stream_en !== 1'b1 || state_dbg !== 4'd9 ||
        retry_count !== 2'd0 || init_fail !== 1'b0) begin
      errors++;
      $display("FAIL nominal_stream se %b st %0d rc %0d if %b required 1/9/0/0",
               stream_en, state_dbg, retry_count, init_fail);
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    drive_tx(8'hFF, "to_1");
    tick(49);
    checks++;
    if (state_dbg !== 4'd3 || retry_count !== 2'd0) begin
      errors++;
      $display("FAIL to_early st %0d rc %0d required 3/0",
               state_dbg, retry_count);
    end
    tick(1);
    checks++;
    if (state_dbg !== 4'd1 || retry_count !== 2'd1) begin
      errors++;
      $display("FAIL to_first st %0d rc %0d required 1/1",
               state_dbg, retry_count);
    end
    drive_tx(8'hFF, "to_2");
    tick(50);
    checks++;
    if (state_dbg !== 4'd1 || retry_count !== 2'd2) begin
      errors++;
      $display("FAIL to_second st %0d rc %0d required 1/2",
               state_dbg, retry_count);
    end
    drive_tx(8'hFF, "to_3");
    tick(50);
    checks++;
    if (state_dbg !== 4'd10 || init_fail !== 1'b1 ||
        retry_count !== 2'd3 || stream_en !== 1'b0) begin
      errors++;
      $display("FAIL to_fail st %0d if %b rc %0d se %b required 10/1/3/0",
               state_dbg, init_fail, retry_count, stream_en);
    end
    tick(5);
    checks++;
    if (state_dbg !== 4'd10) begin
      errors++;
      $display("FAIL fail_hold st %0d required 10", state_dbg);
    end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++;
    if (state_dbg !== 4'd1 || retry_count !== 2'd0 || init_fail !== 1'b0) begin
      errors++;
      $display("FAIL fail_restart st %0d rc %0d if %b required 1/0/0",
               state_dbg, retry_count, init_fail);
    end
    exp_q.push_back(8'hFF);
    wait_req("fail_restart_req");
  endtask

  task automatic test_resend();
    reach_ack_en();
    rx_byte(8'hFE);
    checks++;
    if (state_dbg !== 4'd6 || retry_count !== 2'd1) begin
      errors++;
      $display("FAIL resend st %0d rc %0d required 6/1",
               state_dbg, retry_count);
    end
    drive_tx(8'hF4, "resend_en");
    rx_byte(8'hFA);
    checks++;
    if (stream_en !== 1'b1 || retry_count !== 2'd0) begin
      errors++;
      $display("FAIL resend_stream se %b rc %0d required 1/0",
               stream_en, retry_count);
    end
  endtask

  task automatic test_bad_bat();
    do_reset();
    drive_tx(8'hFF, "bat_rst");
    rx_byte(8'hFA);
    rx_byte(8'hFC);
    checks++;
    if (state_dbg !== 4'd1 || retry_count !== 2'd1) begin
      errors++;
      $display("FAIL bad_bat st %0d rc %0d required 1/1",
               state_dbg, retry_count);
    end
    exp_q.push_back(8'hFF);
    wait_req("bat_retry");
  endtask

  task automatic test_reset_restart();
    do_reset();
    drive_tx(8'hFF, "mid_rst");
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if ({state_dbg, retry_count, stream_en, init_fail} !== 8'h00 ||
        bus.tx_req !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset st %0d rc %0d data %h required 0/0/00",
               state_dbg, retry_count, bus.tx_data);
    end
    tick(9);
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL mid_pwr st %0d required 0", state_dbg);
    end
    tick(1);
    checks++;
    if (state_dbg !== 4'd1) begin
      errors++;
      $display("FAIL mid_pwr_end st %0d required 1", state_dbg);
    end
    exp_q.push_back(8'hFF);
    wait_req("mid_req");
    reach_ack_en();
    rx_byte(8'hFA);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++;
    if (stream_en !== 1'b0 || state_dbg !== 4'd1) begin
      errors++;
      $display("FAIL stream_restart se %b st %0d required 0/1",
               stream_en, state_dbg);
    end
    exp_q.push_back(8'hFF);
    wait_req("restart_req");
  endtask

  task automatic test_tie_breaks();
    do_reset();
    drive_tx(8'hFF, "tie_rst");
    tick(49);
    rx_byte(8'hFA);
    checks++;
    if (state_dbg !== 4'd4 || retry_count !== 2'd0) begin
      errors++;
      $display("FAIL tie_rx_wins st %0d rc %0d required 4/0",
               state_dbg, retry_count);
    end
    do_reset();
    bus.tx_busy = 1'b1;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (bus.tx_req !== 1'b0 || state_dbg !== 4'd1) begin
        errors++;
        $display("FAIL busy_hold req %b st %0d required 0/1",
                 bus.tx_req, state_dbg);
      end
    end
    exp_q.push_back(8'hFF);
    bus.tx_busy = 1'b0;
    wait_req("busy_release");
    checks++;
    if (state_dbg !== 4'd2) begin
      errors++;
      $display("FAIL busy_tx st %0d required 2", state_dbg);
    end
  endtask

  initial begin
    reset        = 1'b1;
    restart      = 1'b0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_nominal();
    test_ack_timeout();
    test_resend();
    test_bad_bat();
    test_reset_restart();
    test_tie_breaks();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
